// File: rtl/fp32_bf16_packer.sv
// fp32_bf16_packer: FP32-to-BF16 down-converter packing PACK input beats of LANES lanes into one output word.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_data/in_last/rnd_mode input beat
// (rnd_mode 0 = RNE, 1 = RTZ); out_valid/out_ready/out_data/out_beats/out_last output word.
// Optional: define FP32_BF16_NAN_CANON_EN to map every NaN lane to a sign-preserving canonical quiet NaN.
module fp32_bf16_packer #(
  parameter int LANES = 8,
  parameter int PACK = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*32-1:0]         in_data,
  input  logic                        in_last,
  input  logic                        rnd_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PACK*LANES*16-1:0]    out_data,
  output logic [$clog2(PACK+1)-1:0]   out_beats,
  output logic                        out_last
);
  localparam int BW = LANES*16;
  localparam int CW = PACK > 1 ? $clog2(PACK) : 1;
  localparam int OBW = $clog2(PACK+1);
  logic [BW-1:0] conv;
  logic [CW-1:0] cnt;
  logic [PACK-1:0][BW-1:0] held, word;
  logic close, fire;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0] x;
    logic inc;
    assign x = in_data[i*32 +: 32];
    assign inc = !rnd_mode && x[15] && (x[16] || |x[14:0]);
`ifdef FP32_BF16_NAN_CANON_EN
    assign conv[i*16 +: 16] = (&x[30:23] && |x[22:0]) ? {x[31], 15'h7FC0} : x[31:16] + {15'd0, inc};
`else
    assign conv[i*16 +: 16] = x[31:16] + {15'd0, inc};
`endif
  end
  assign close = (cnt == CW'(PACK-1)) || in_last;
  // only a word-closing beat needs the output register free
  assign in_ready = !rst && (!close || !out_valid || out_ready);
  assign fire = in_valid && in_ready;
  if (PACK > 1) begin : g_stage
    logic [PACK-2:0][BW-1:0] stage;
    logic [CW-1:0] c;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        c <= '0;
        stage <= '0;
      end else if (fire) begin
        c <= close ? '0 : c + 1'b1;
        for (int k = 0; k < PACK-1; k++)
          if (!close && c == CW'(k)) stage[k] <= conv;
      end
    end
    assign held = {{BW{1'b0}}, stage};
    assign cnt = c;
  end else begin : g_nostage
    assign held = '0;
    assign cnt = '0;
  end
  always_comb begin
    word = '0;
    for (int k = 0; k < PACK; k++)
      word[k] = CW'(k) < cnt ? held[k] : CW'(k) == cnt ? conv : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_beats <= '0;
      out_last <= 1'b0;
    end else if (fire && close) begin
      out_valid <= 1'b1;
      out_data <= word;
      out_beats <= OBW'(cnt) + OBW'(1);
      out_last <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp32_bf16_packer.sv
// tb_fp32_bf16_packer: directed self-checking bench for fp32_bf16_packer (LANES=8, PACK=2).
module tb_fp32_bf16_packer;
  localparam int LANES = 8;
  localparam int PACK = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [LANES*32-1:0] in_data = '0;
  logic in_last = 1'b0;
  logic rnd_mode = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [PACK*LANES*16-1:0] out_data;
  logic [1:0] out_beats;
  logic out_last;
  int passed = 0;
  int total = 0;
  logic [255:0] w1;
  fp32_bf16_packer #(.LANES(LANES), .PACK(PACK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beats(out_beats), .out_last(out_last)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] rep(input logic [15:0] v);
    return {LANES{v}};
  endfunction
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic send(input logic [31:0] x, input logic last, input logic rm);
    int n;
    in_valid = 1'b1;
    in_data = {LANES{x}};
    in_last = last;
    rnd_mode = rm;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n == 50) chk("send_timeout", 256'(in_ready), 256'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic chk_word(input string tag, input logic [255:0] d, input logic [1:0] b, input logic l);
    chk({tag, "_valid"}, 256'(out_valid), 256'(1));
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_beats"}, 256'(out_beats), 256'(b));
    chk({tag, "_last"}, 256'(out_last), 256'(l));
  endtask
  initial begin
    @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_data", out_data, 256'(0));
    chk("rst_out_beats", 256'(out_beats), 256'(0));
    chk("rst_out_last", 256'(out_last), 256'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(32'h3F808000, 1'b0, 1'b0);
    chk("stage_no_valid", 256'(out_valid), 256'(0));
    send(32'h3F818000, 1'b0, 1'b0);
    chk_word("rne_ties", {rep(16'h3F82), rep(16'h3F80)}, 2'd2, 1'b0);
    send(32'h3F808001, 1'b0, 1'b0);
    send(32'h3F80FFFF, 1'b0, 1'b1);
    chk_word("rne_sticky_rtz", {rep(16'h3F80), rep(16'h3F81)}, 2'd2, 1'b0);
    send(32'h7F7FFFFF, 1'b0, 1'b0);
    send(32'hFF7FFFFF, 1'b0, 1'b0);
    chk_word("overflow", {rep(16'hFF80), rep(16'h7F80)}, 2'd2, 1'b0);
    send(32'h7F800001, 1'b0, 1'b0);
    send(32'hFFC00000, 1'b0, 1'b0);
`ifdef FP32_BF16_NAN_CANON_EN
    chk_word("nan", {rep(16'hFFC0), rep(16'h7FC0)}, 2'd2, 1'b0);
`else
    chk_word("nan", {rep(16'hFFC0), rep(16'h7F80)}, 2'd2, 1'b0);
`endif
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1;
      in_data = {LANES{32'h3F800000 + (32'(j) << 16)}};
      rnd_mode = 1'b1;
      #1;
      chk($sformatf("stream_in_ready%0d", j), 256'(in_ready), 256'(1));
      @(posedge clk);
      #1;
      chk($sformatf("stream_valid%0d", j), 256'(out_valid), 256'(j % 2));
      if (j % 2 == 1)
        chk($sformatf("stream_data%0d", j), out_data,
            {rep(16'h3F80 + 16'(j)), rep(16'h3F80 + 16'(j - 1))});
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_drain", 256'(out_valid), 256'(0));
    out_ready = 1'b0;
    send(32'h40400000, 1'b0, 1'b0);
    send(32'h40800000, 1'b0, 1'b0);
    w1 = {rep(16'h4080), rep(16'h4040)};
    chk_word("bp_first", w1, 2'd2, 1'b0);
    send(32'h40A00000, 1'b0, 1'b0);
    chk("bp_stage_hold", out_data, w1);
    in_valid = 1'b1;
    in_data = {LANES{32'h40C00000}};
    for (int j = 0; j < 4; j++) begin
      #1;
      chk($sformatf("bp_stall%0d", j), 256'(in_ready), 256'(0));
      @(posedge clk);
      #1;
      chk($sformatf("bp_stable%0d", j), out_data, w1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", 256'(in_ready), 256'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_word("bp_second", {rep(16'h40C0), rep(16'h40A0)}, 2'd2, 1'b0);
    @(posedge clk);
    #1;
    chk("bp_drain", 256'(out_valid), 256'(0));
    send(32'h40000000, 1'b1, 1'b0);
    chk_word("early_close", {128'h0, rep(16'h4000)}, 2'd1, 1'b1);
    send(32'h40100000, 1'b0, 1'b0);
    send(32'h40200000, 1'b1, 1'b0);
    chk_word("last_full", {rep(16'h4020), rep(16'h4010)}, 2'd2, 1'b1);
    send(32'h41000000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 256'(in_ready), 256'(0));
    chk("midrst_out_valid", 256'(out_valid), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'h42000000, 1'b0, 1'b0);
    chk("postrst_stage", 256'(out_valid), 256'(0));
    send(32'h43000000, 1'b0, 1'b0);
    chk_word("postrst", {rep(16'h4300), rep(16'h4200)}, 2'd2, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
